lm32_sim_trap_monitor: RTL and testbench

LM32_SIM_TRAP_MONITOR -- requirements
Module: lm32_sim_trap_monitor

---
 rtl/lm32_sim_trap_monitor.sv | 184 ++++++++++++++++++
 tb/tb_lm32_sim_trap_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_sim_trap_monitor.sv
// ---------------------------------------------------------------------------
// lm32_sim_trap_monitor
//
// Simulation-termination monitor for one or more LM32 cores. Tracks each
// core's scall instruction down the X -> M -> W pipeline and ends the run
// (sticky "done") on the first exit system call, bus error (when fatal) or
// watchdog expiry. Records why and which core, plus the exit code.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   reset_n      : asynchronous active-low reset
//   scall_x      : per-core scall decoded in X stage
//   valid_x      : per-core X-stage valid
//   valid_m      : per-core M-stage valid
//   stall_m      : per-core M-stage stall (holds the scall pipeline)
//   i_err, d_err : per-core instruction / data bus error
//   reg_r8       : per-core r8 (system call number), core k at [k*DATA_W +: DATA_W]
//   reg_r1       : per-core r1 (exit code), same packing
//   done         : sticky termination flag
//   cause        : 0 none, 1 exit, 2 ibus error, 3 dbus error, 4 timeout
//   cause_cpu    : index of the terminating core (0 for timeout)
//   exit_code    : r1 of the exiting core, 0 for other causes
//   err_count    : saturating count of cycles with any bus error
//   cycle_count  : saturating cycles since reset release, frozen once done
// ---------------------------------------------------------------------------
module lm32_sim_trap_monitor #(
  parameter int NUM_CPU        = 1,
  parameter int DATA_W         = 32,
  parameter int EXIT_SCALL_NUM = 1,
  parameter int ERR_FATAL      = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n,
  input  logic [NUM_CPU-1:0]        scall_x,
  input  logic [NUM_CPU-1:0]        valid_x,
  input  logic [NUM_CPU-1:0]        valid_m,
  input  logic [NUM_CPU-1:0]        stall_m,
  input  logic [NUM_CPU-1:0]        i_err,
  input  logic [NUM_CPU-1:0]        d_err,
  input  logic [NUM_CPU*DATA_W-1:0] reg_r8,
  input  logic [NUM_CPU*DATA_W-1:0] reg_r1,
  output logic                      done,
  output logic [2:0]                cause,
  output logic [2:0]                cause_cpu,
  output logic [DATA_W-1:0]         exit_code,
  output logic [CNT_W-1:0]          err_count,
  output logic [CNT_W-1:0]          cycle_count
);

  typedef enum logic {S_RUN, S_DONE} state_e;

  localparam logic [2:0] CAUSE_EXIT    = 3'd1;
  localparam logic [2:0] CAUSE_IBUS    = 3'd2;
  localparam logic [2:0] CAUSE_DBUS    = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  // Last cycle_count value before the watchdog fires; unused when disabled.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NUM_CPU-1:0]  scall_m_q, scall_m_d;
  logic [NUM_CPU-1:0]  scall_w_q, scall_w_d;
  logic                done_q, done_d;
  logic [2:0]          cause_q, cause_d;
  logic [2:0]          cpu_q, cpu_d;
  logic [DATA_W-1:0]   exit_code_q, exit_code_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;

  // Event scan results
  logic                err_any;
  logic                err_hit;
  logic [2:0]          err_cause;
  logic [2:0]          err_cpu;
  logic                exit_hit;
  logic [2:0]          exit_cpu;
  logic [DATA_W-1:0]   exit_r1;
  logic                timeout_hit;

  // A stalled M stage freezes both the M and W scall flags of that core.
  assign scall_m_d = (stall_m & scall_m_q) | (~stall_m & scall_x & valid_x);
  assign scall_w_d = (stall_m & scall_w_q) | (~stall_m & scall_m_q & valid_m);

  // Scan from the highest core down so the lowest-indexed hit is left last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    err_hit   = 1'b0;
    err_cause = CAUSE_DBUS;
    err_cpu   = 3'd0;
    exit_hit  = 1'b0;
    exit_cpu  = 3'd0;
    exit_r1   = '0;
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      if (i_err[k] || d_err[k]) begin
        err_hit   = 1'b1;
        err_cpu   = 3'(k);
        err_cause = i_err[k] ? CAUSE_IBUS : CAUSE_DBUS;
      end
      if (scall_w_q[k] && (reg_r8[k*DATA_W +: DATA_W] == DATA_W'(EXIT_SCALL_NUM))) begin
        exit_hit = 1'b1;
        exit_cpu = 3'(k);
        exit_r1  = reg_r1[k*DATA_W +: DATA_W];
      end
    end
  end

  assign err_any     = |(i_err | d_err);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TIMEOUT_LAST);

  // Next-state and termination record
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    cause_d     = cause_q;
    cpu_d       = cpu_q;
    exit_code_d = exit_code_q;
    if (state_q == S_RUN) begin
      if ((ERR_FATAL != 0) && err_hit) begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        cause_d     = err_cause;
        cpu_d       = err_cpu;
        exit_code_d = '0;
      end else if (exit_hit) begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        cause_d     = CAUSE_EXIT;
        cpu_d       = exit_cpu;
        exit_code_d = exit_r1;
      end else if (timeout_hit) begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        cause_d     = CAUSE_TIMEOUT;
        cpu_d       = 3'd0;
        exit_code_d = '0;
      end
    end
  end

  // Counters: errors count in both states, cycles only while running.
  always_comb begin
    err_count_d   = err_count_q;
    cycle_count_d = cycle_count_q;
    if (err_any && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
    if ((state_q == S_RUN) && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      scall_m_q     <= '0;
      scall_w_q     <= '0;
      done_q        <= 1'b0;
      cause_q       <= 3'd0;
      cpu_q         <= 3'd0;
      exit_code_q   <= '0;
      err_count_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      scall_m_q     <= scall_m_d;
      scall_w_q     <= scall_w_d;
      done_q        <= done_d;
      cause_q       <= cause_d;
      cpu_q         <= cpu_d;
      exit_code_q   <= exit_code_d;
      err_count_q   <= err_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign done        = done_q;
  assign cause       = cause_q;
  assign cause_cpu   = cpu_q;
  assign exit_code   = exit_code_q;
  assign err_count   = err_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_lm32_sim_trap_monitor.sv
// ---------------------------------------------------------------------------
// tb_lm32_sim_trap_monitor
//
// Five monitor instances share one 4-core stimulus bus:
//   u_a : defaults (1 core, fatal errors, no watchdog)
//   u_f : 4 cores, fatal errors
//   u_n : 4 cores, errors counted only
//   u_t : 1 core, watchdog of 50 cycles
//   u_s : 1 core, 4-bit counters, errors counted only
// Single-core instances see core 0 of the bus. Inputs change and outputs are
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_lm32_sim_trap_monitor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   scall_x, valid_x, valid_m, stall_m, i_err, d_err;
  logic [127:0] reg_r8, reg_r1;

  int checks   = 0;
  int failures = 0;

  logic        a_done, f_done, n_done, t_done, s_done;
  logic [2:0]  a_cause, f_cause, n_cause, t_cause, s_cause;
  logic [2:0]  a_cpu, f_cpu, n_cpu, t_cpu, s_cpu;
  logic [31:0] a_exit, f_exit, n_exit, t_exit, s_exit;
  logic [31:0] a_err, f_err, n_err, t_err;
  logic [31:0] a_cyc, f_cyc, n_cyc, t_cyc;
  logic [3:0]  s_err, s_cyc;

  always #5 clk = ~clk;

  lm32_sim_trap_monitor u_a (
    .clk_i(clk), .reset_n(reset_n), .scall_x(scall_x[0]), .valid_x(valid_x[0]),
    .valid_m(valid_m[0]), .stall_m(stall_m[0]), .i_err(i_err[0]), .d_err(d_err[0]),
    .reg_r8(reg_r8[31:0]), .reg_r1(reg_r1[31:0]), .done(a_done), .cause(a_cause),
    .cause_cpu(a_cpu), .exit_code(a_exit), .err_count(a_err), .cycle_count(a_cyc));

  lm32_sim_trap_monitor #(.NUM_CPU(4), .ERR_FATAL(1)) u_f (
    .clk_i(clk), .reset_n(reset_n), .scall_x(scall_x), .valid_x(valid_x),
    .valid_m(valid_m), .stall_m(stall_m), .i_err(i_err), .d_err(d_err),
    .reg_r8(reg_r8), .reg_r1(reg_r1), .done(f_done), .cause(f_cause),
    .cause_cpu(f_cpu), .exit_code(f_exit), .err_count(f_err), .cycle_count(f_cyc));

  lm32_sim_trap_monitor #(.NUM_CPU(4), .ERR_FATAL(0)) u_n (
    .clk_i(clk), .reset_n(reset_n), .scall_x(scall_x), .valid_x(valid_x),
    .valid_m(valid_m), .stall_m(stall_m), .i_err(i_err), .d_err(d_err),
    .reg_r8(reg_r8), .reg_r1(reg_r1), .done(n_done), .cause(n_cause),
    .cause_cpu(n_cpu), .exit_code(n_exit), .err_count(n_err), .cycle_count(n_cyc));

  lm32_sim_trap_monitor #(.TIMEOUT_CYCLES(50)) u_t (
    .clk_i(clk), .reset_n(reset_n), .scall_x(scall_x[0]), .valid_x(valid_x[0]),
    .valid_m(valid_m[0]), .stall_m(stall_m[0]), .i_err(i_err[0]), .d_err(d_err[0]),
    .reg_r8(reg_r8[31:0]), .reg_r1(reg_r1[31:0]), .done(t_done), .cause(t_cause),
    .cause_cpu(t_cpu), .exit_code(t_exit), .err_count(t_err), .cycle_count(t_cyc));

  lm32_sim_trap_monitor #(.CNT_W(4), .ERR_FATAL(0)) u_s (
    .clk_i(clk), .reset_n(reset_n), .scall_x(scall_x[0]), .valid_x(valid_x[0]),
    .valid_m(valid_m[0]), .stall_m(stall_m[0]), .i_err(i_err[0]), .d_err(d_err[0]),
    .reg_r8(reg_r8[31:0]), .reg_r1(reg_r1[31:0]), .done(s_done), .cause(s_cause),
    .cause_cpu(s_cpu), .exit_code(s_exit), .err_count(s_err), .cycle_count(s_cyc));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset everything, idle the inputs, release 1 ns after an edge so the
  // next rising edge is the first monitored one.
  task automatic do_reset();
    reset_n = 1'b0;
    scall_x = '0; valid_x = '0; valid_m = '0; stall_m = '0;
    i_err = '0; d_err = '0; reg_r8 = '0; reg_r1 = '0;
    tick(2);
    reset_n = 1'b1;
  endtask

  // Launch an scall on core `core` (valid through M) and sample it at the next edge.
  task automatic launch_scall(input int core);
    scall_x[core] = 1'b1;
    valid_x[core] = 1'b1;
    valid_m[core] = 1'b1;
    tick();
    scall_x[core] = 1'b0;
    valid_x[core] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_done, a_cause, a_cpu, a_exit, a_err, a_cyc} !== '0) begin
      failures++;
      $display("FAIL reset_a: got done=%0b cause=%0d cpu=%0d exit=%0h err=%0d cyc=%0d required all 0",
               a_done, a_cause, a_cpu, a_exit, a_err, a_cyc);
    end
    checks++;
    if ({f_done, f_cause, f_cpu, f_exit, f_err, f_cyc} !== '0) begin
      failures++;
      $display("FAIL reset_f: got done=%0b cause=%0d cpu=%0d exit=%0h err=%0d cyc=%0d required all 0",
               f_done, f_cause, f_cpu, f_exit, f_err, f_cyc);
    end
  endtask

  // Exit call, no stall: done appears after the second edge following the
  // sampling edge (X->M at sampling edge, M->W, then W->done).
  task automatic test_exit();
    do_reset();
    reg_r8[31:0] = 32'd1;
    reg_r1[31:0] = 32'd7;
    launch_scall(0);
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL exit_early: got done=%0b required 0", a_done);
    end
    tick();
    checks++;
    if ({a_done, a_cause, a_cpu, a_exit} !== {1'b1, 3'd1, 3'd0, 32'd7}) begin
      failures++;
      $display("FAIL exit_done: got done=%0b cause=%0d cpu=%0d exit=%0d required 1/1/0/7",
               a_done, a_cause, a_cpu, a_exit);
    end
  endtask

  task automatic test_stall();
    do_reset();
    reg_r8[31:0] = 32'd1;
    reg_r1[31:0] = 32'd7;
    launch_scall(0);
    stall_m[0] = 1'b1;
    tick(4);
    stall_m[0] = 1'b0;
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL stall_early: got done=%0b required 0", a_done);
    end
    tick();
    checks++;
    if ({a_done, a_cause, a_exit} !== {1'b1, 3'd1, 32'd7}) begin
      failures++;
      $display("FAIL stall_done: got done=%0b cause=%0d exit=%0d required 1/1/7",
               a_done, a_cause, a_exit);
    end
  endtask

  task automatic test_wrong_call();
    do_reset();
    reg_r8[31:0] = 32'd2;
    reg_r1[31:0] = 32'd7;
    launch_scall(0);
    tick(6);
    checks++;
    if ({a_done, a_cause} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL wrong_call: got done=%0b cause=%0d required 0/0", a_done, a_cause);
    end
  endtask

  // Core 2 exit coincides with a core 1 data-bus error.
  task automatic test_err_vs_exit();
    do_reset();
    reg_r8[95:64] = 32'd1;
    reg_r1[95:64] = 32'h55;
    launch_scall(2);
    tick();
    d_err[1] = 1'b1;
    tick();
    d_err[1] = 1'b0;
    checks++;
    if ({f_done, f_cause, f_cpu, f_exit} !== {1'b1, 3'd3, 3'd1, 32'd0}) begin
      failures++;
      $display("FAIL fatal_err: got done=%0b cause=%0d cpu=%0d exit=%0h required 1/3/1/0",
               f_done, f_cause, f_cpu, f_exit);
    end
    checks++;
    if ({n_done, n_cause, n_cpu, n_exit, n_err} !== {1'b1, 3'd1, 3'd2, 32'h55, 32'd1}) begin
      failures++;
      $display("FAIL nonfatal_exit: got done=%0b cause=%0d cpu=%0d exit=%0h err=%0d required 1/1/2/55/1",
               n_done, n_cause, n_cpu, n_exit, n_err);
    end
    // Later events are ignored once done, but errors still count.
    i_err[0] = 1'b1;
    tick();
    i_err[0] = 1'b0;
    checks++;
    if ({f_cause, f_cpu, f_err} !== {3'd3, 3'd1, 32'd2}) begin
      failures++;
      $display("FAIL frozen: got cause=%0d cpu=%0d err=%0d required 3/1/2", f_cause, f_cpu, f_err);
    end
  endtask

  // Lowest core wins, and i_err beats d_err on the same core.
  task automatic test_err_priority();
    do_reset();
    i_err[3] = 1'b1; d_err[3] = 1'b1; d_err[2] = 1'b1;
    tick();
    checks++;
    if ({f_cause, f_cpu} !== {3'd3, 3'd2}) begin
      failures++;
      $display("FAIL core_prio: got cause=%0d cpu=%0d required 3/2", f_cause, f_cpu);
    end
    do_reset();
    i_err[3] = 1'b1; d_err[3] = 1'b1;
    tick();
    checks++;
    if ({f_cause, f_cpu} !== {3'd2, 3'd3}) begin
      failures++;
      $display("FAIL ibus_prio: got cause=%0d cpu=%0d required 2/3", f_cause, f_cpu);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(49);
    checks++;
    if ({t_done, t_cyc} !== {1'b0, 32'd49}) begin
      failures++;
      $display("FAIL timeout_pre: got done=%0b cyc=%0d required 0/49", t_done, t_cyc);
    end
    tick();
    checks++;
    if ({t_done, t_cause, t_cpu, t_cyc} !== {1'b1, 3'd4, 3'd0, 32'd50}) begin
      failures++;
      $display("FAIL timeout_done: got done=%0b cause=%0d cpu=%0d cyc=%0d required 1/4/0/50",
               t_done, t_cause, t_cpu, t_cyc);
    end
    tick(5);
    checks++;
    if (t_cyc !== 32'd50) begin
      failures++;
      $display("FAIL timeout_freeze: got cyc=%0d required 50", t_cyc);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    i_err[0] = 1'b1;
    tick(14);
    checks++;
    if (s_err !== 4'd14) begin
      failures++;
      $display("FAIL sat_pre: got err=%0d required 14", s_err);
    end
    tick(6);
    i_err[0] = 1'b0;
    checks++;
    if ({s_done, s_err} !== {1'b0, 4'd15}) begin
      failures++;
      $display("FAIL sat_err: got done=%0b err=%0d required 0/15", s_done, s_err);
    end
  endtask

  // Reset while done clears outputs without a clock edge, then a new exit works.
  task automatic test_back_to_back();
    do_reset();
    i_err[0] = 1'b1;
    tick();
    i_err[0] = 1'b0;
    checks++;
    if ({a_done, a_cause} !== {1'b1, 3'd2}) begin
      failures++;
      $display("FAIL b2b_first: got done=%0b cause=%0d required 1/2", a_done, a_cause);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_done, a_cause, a_cpu, a_exit, a_err, a_cyc} !== '0) begin
      failures++;
      $display("FAIL async_reset: got done=%0b cause=%0d cpu=%0d exit=%0h err=%0d cyc=%0d required all 0",
               a_done, a_cause, a_cpu, a_exit, a_err, a_cyc);
    end
    tick();
    reset_n = 1'b1;
    reg_r8[31:0] = 32'd1;
    reg_r1[31:0] = 32'd3;
    launch_scall(0);
    tick(2);
    checks++;
    if ({a_done, a_cause, a_exit} !== {1'b1, 3'd1, 32'd3}) begin
      failures++;
      $display("FAIL b2b_exit: got done=%0b cause=%0d exit=%0d required 1/1/3", a_done, a_cause, a_exit);
    end
  endtask

  initial begin
    test_reset();
    test_exit();
    test_stall();
    test_wrong_call();
    test_err_vs_exit();
    test_err_priority();
    test_timeout();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
